// File: rtl/burst_decode.sv
// Window decoder for a burst-coded stochastic bitstream: per window of
// 2^WLOG2 enabled samples, reports ones, mode toggles and longest run.
module burst_decode #(
  parameter int WLOG2 = 3,
  parameter int RUNW  = 8
) (
  input  logic             CLK,
  input  logic             INIT_N,
  input  logic             EN,
  input  logic             IN,
  input  logic             READY,
  output logic             VALID,
  output logic [WLOG2:0]   ONES,
  output logic [WLOG2:0]   TOGGLES,
  output logic [RUNW-1:0]  MAXRUN,
  output logic             OVF
);

  localparam int OW = WLOG2 + 1;

  logic [WLOG2-1:0] cnt_q;
  logic [OW-1:0]    ones_q, ones_d;
  logic [OW-1:0]    tog_q, tog_d;
  logic [RUNW-1:0]  run_q, run_d;
  logic [RUNW-1:0]  max_q, max_d;
  logic             prev_q;
  logic             first, last, toggle;

  always_comb begin
    first  = (cnt_q == '0);
    last   = (cnt_q == '1);
    toggle = IN ^ prev_q;
    ones_d = ones_q + OW'(IN);
    tog_d  = tog_q + OW'(toggle);
    // Runs restart at each window start and on every toggle
    if (first || toggle) begin
      run_d = RUNW'(1);
    end else if (run_q == '1) begin
      run_d = run_q;
    end else begin
      run_d = run_q + RUNW'(1);
    end
    max_d = (run_d > max_q) ? run_d : max_q;
  end

  always_ff @(posedge CLK) begin
    if (!INIT_N) begin
      cnt_q   <= '0;
      ones_q  <= '0;
      tog_q   <= '0;
      run_q   <= '0;
      max_q   <= '0;
      prev_q  <= 1'b0;
      VALID   <= 1'b0;
      OVF     <= 1'b0;
      ONES    <= '0;
      TOGGLES <= '0;
      MAXRUN  <= '0;
    end else begin
      // A transfer drops VALID unless a window close reloads it below
      if (VALID && READY) begin
        VALID <= 1'b0;
      end
      if (EN) begin
        prev_q <= IN;
        cnt_q  <= cnt_q + WLOG2'(1);
        if (last) begin
          ONES    <= ones_d;
          TOGGLES <= tog_d;
          MAXRUN  <= max_d;
          VALID   <= 1'b1;
          if (VALID && !READY) begin
            OVF <= 1'b1;
          end
          ones_q <= '0;
          tog_q  <= '0;
          run_q  <= '0;
          max_q  <= '0;
        end else begin
          ones_q <= ones_d;
          tog_q  <= tog_d;
          run_q  <= run_d;
          max_q  <= max_d;
        end
      end
    end
  end

endmodule

// File: doc/burst_decode.md
BURST_DECODE -- requirements
Module: burst_decode

Interface
REQ-001 SHALL provide parameter WLOG2, default 3: window length is 2^WLOG2 enabled samples.
REQ-002 SHALL provide parameter RUNW, default 8: width of the run-length counter and of MAXRUN.
REQ-003 SHALL have one clock and a synchronous, active-low reset.
REQ-004 Ports:
  - CLK  in  1: clock, all state on rising edge.
  - INIT_N  in  1: synchronous active-low reset.
  - EN  in  1: sample enable.
  - IN  in  1: burst-coded stochastic bitstream, e.g. from the burst gate output.
  - READY  in  1: consumer accepts the result.
  - VALID  out  1: a result is held.
  - ONES  out  WLOG2+1: count of 1 samples in the window.
  - TOGGLES  out  WLOG2+1: count of mode switches in the window.
  - MAXRUN  out  RUNW: longest run of equal bits in the window, saturating.
  - OVF  out  1: sticky flag, an unconsumed result was overwritten.

Function
REQ-005 SHALL sample IN only on rising CLK edges where INIT_N=1 and EN=1; EN=0 freezes all window state.
REQ-006 SHALL keep a WLOG2-bit sample counter that increments per sample and wraps 2^WLOG2-1 -> 0; the sample taken at count 2^WLOG2-1 closes the window.
REQ-007 SHALL accumulate ones per window; range 0..2^WLOG2 inclusive, no overflow at WLOG2+1 bits.
REQ-008 SHALL count a toggle when a sample differs from the previous sample.
REQ-009 SHALL carry the previous sample across window boundaries, so the first sample of a window may toggle.
REQ-010 The previous-sample register SHALL be 0 after reset.
REQ-011 SHALL keep a current-run counter:
  - set to 1 on the first sample of each window and on each toggle;
  - otherwise increment, saturating at 2^RUNW-1.
  - Runs do not span windows.
REQ-012 SHALL track the window maximum of the current-run counter, including the closing sample.
REQ-013 On a window-closing edge, SHALL load ONES/TOGGLES/MAXRUN with final values including the closing sample, set VALID=1, and clear the accumulators for the next window on the same edge.
REQ-014 Load latency SHALL be 0 cycles after the closing edge (outputs visible in the following cycle).
REQ-015 Handshake: a transfer occurs on an edge with VALID=1 and READY=1. After a transfer with no simultaneous window close, VALID SHALL be 0.
REQ-016 Outputs SHALL be stable while VALID=1 and READY=0, except on overwrite (REQ-017).
REQ-017 Window close with VALID=1 and READY=0 SHALL overwrite the outputs with the new window (newest wins), keep VALID=1, and set OVF=1.
REQ-018 Window close with VALID=1 and READY=1 on the same edge SHALL load the new result, keep VALID=1, and leave OVF unchanged.
REQ-019 OVF SHALL be cleared only by reset.
REQ-020 The handshake SHALL operate regardless of EN.
REQ-021 READY while VALID=0 SHALL have no effect.

Reset
REQ-022 With INIT_N=0 at a rising edge, SHALL clear:
  - VALID, OVF, ONES, TOGGLES, MAXRUN to 0;
  - the sample counter, accumulators, run counter and previous-sample register to 0.
REQ-023 Reset SHALL take priority over EN, IN and READY.
REQ-024 Reset mid-window SHALL discard the partial window; the next window starts with the first enabled sample after INIT_N rises.
REQ-025 Before the first edge with INIT_N=0, no output value is guaranteed.

Verification
REQ-026 WLOG2=3, reset, READY=1, EN=1, IN=1 for 8 cycles -> one-cycle VALID pulse; ONES=8, TOGGLES=1, MAXRUN=8, OVF=0.
REQ-027 IN=1,0,1,0,1,0,1,0 after reset -> ONES=4, TOGGLES=8, MAXRUN=1.
REQ-028 IN=0,0,0,1,1,1,1,1 after reset -> ONES=5, TOGGLES=1, MAXRUN=5.
REQ-029 READY=0 over two windows (window 1 all 1, window 2 all 0) -> VALID stays 1 and OVF=1.
  - Outputs show ONES=0, TOGGLES=1, MAXRUN=8.
  - READY=1 then drops VALID next cycle; OVF stays 1.
REQ-030 EN pattern 1,0,1,0,... with IN=1 -> window closes after 16 clocks (8 enabled samples), ONES=8; INIT_N=0 after 5 samples then 8 samples of IN=1 -> single result ONES=8.
REQ-031 RUNW=2, IN=1 for 8 samples -> MAXRUN=3 (saturated), ONES=8.
